// File: rtl/mips_ctrl_pkg.sv
// Shared state encodings, opcode constants and control bus for the
// multicycle MIPS control unit.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    localparam int unsigned OP_RTYPE = 'h00;
    localparam int unsigned OP_J     = 'h02;
    localparam int unsigned OP_BEQ   = 'h04;
    localparam int unsigned OP_BNE   = 'h05;
    localparam int unsigned OP_ADDI  = 'h08;
    localparam int unsigned OP_LW    = 'h23;
    localparam int unsigned OP_SW    = 'h2B;

    typedef struct packed {
        logic       iord;
        logic       alusrca;
        logic       regdst;
        logic       memtoreg;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

endpackage

// File: rtl/control_output_decoder.sv
// Moore output decode: maps the current state onto the control bus.
// Unused encodings decode to an all-zero bus.
module control_output_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_e'(state_i))
            S_FETCH: begin
                ctrl_o.irwrite = 1'b1;
                ctrl_o.alusrcb = 2'b01;
                ctrl_o.pcwrite = 1'b1;
            end
            S_DECODE: ctrl_o.alusrcb = 2'b11;
            S_MEMADR, S_ADDIEXEC: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = 2'b10;
            end
            S_MEMREAD: ctrl_o.iord = 1'b1;
            S_MEMWRITE: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.memwrite = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.memtoreg = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            S_ALUWB: begin
                ctrl_o.regdst   = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            S_ADDIWB: ctrl_o.regwrite = 1'b1;
            S_EXECUTE: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = 2'b10;
            end
            S_BRANCH: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = 2'b01;
                ctrl_o.pcsrc   = 2'b01;
                ctrl_o.branch  = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pcsrc   = 2'b10;
                ctrl_o.pcwrite = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM (lw/sw/R/beq/addi/j).
// Define CTRL_BNE_EN to add bne through the BRANCH state.
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_LENGTH = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [OPCODE_LENGTH-1:0] Opcode,
    input  logic                     Zero,
    output logic                     IorD,
    output logic                     ALUSrcA,
    output logic                     RegDst,
    output logic                     MemtoReg,
    output logic                     IRWrite,
    output logic                     MemWrite,
    output logic                     RegWrite,
    output logic [1:0]               ALUSrcB,
    output logic [1:0]               ALUOp,
    output logic [1:0]               PCSrc,
    output logic                     PCEn,
    output logic                     Illegal_op
);

    state_e state_q, state_d, state_eff;
    ctrl_t  ctrl;
    logic   is_mem, is_r, is_beq, is_addi, is_j, is_bne;
    logic   is_legal, zero_eff;

    assign is_mem  = (Opcode == OPCODE_LENGTH'(OP_LW)) ||
                     (Opcode == OPCODE_LENGTH'(OP_SW));
    assign is_r    = (Opcode == OPCODE_LENGTH'(OP_RTYPE));
    assign is_beq  = (Opcode == OPCODE_LENGTH'(OP_BEQ));
    assign is_addi = (Opcode == OPCODE_LENGTH'(OP_ADDI));
    assign is_j    = (Opcode == OPCODE_LENGTH'(OP_J));

`ifdef CTRL_BNE_EN
    logic branch_ne_q, branch_ne_d;
    assign is_bne = (Opcode == OPCODE_LENGTH'(OP_BNE));
`else
    assign is_bne = 1'b0;
`endif

    assign is_legal = is_mem | is_r | is_beq | is_addi | is_j | is_bne;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef CTRL_BNE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_ne_q <= 1'b0;
        end else begin
            branch_ne_q <= branch_ne_d;
        end
    end

    always_comb begin
        branch_ne_d = branch_ne_q;
        if (state_q == S_DECODE) begin
            branch_ne_d = is_bne;
        end
    end

    assign zero_eff = branch_ne_q ? ~Zero : Zero;
`else
    assign zero_eff = Zero;
`endif

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    is_mem:  state_d = S_MEMADR;
                    is_r:    state_d = S_EXECUTE;
                    is_beq:  state_d = S_BRANCH;
                    is_bne:  state_d = S_BRANCH;
                    is_addi: state_d = S_ADDIEXEC;
                    is_j:    state_d = S_JUMP;
                    default: state_d = S_FETCH;
                endcase
            end
            // Anything but sw takes the harmless read path
            S_MEMADR: begin
                if (Opcode == OPCODE_LENGTH'(OP_SW)) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Reset forces the FETCH decode so no write strobe leaks out
    assign state_eff = reset ? S_FETCH : state_q;

    control_output_decoder u_dec (
        .state_i (state_eff),
        .ctrl_o  (ctrl)
    );

    assign IorD       = ctrl.iord;
    assign ALUSrcA    = ctrl.alusrca;
    assign RegDst     = ctrl.regdst;
    assign MemtoReg   = ctrl.memtoreg;
    assign IRWrite    = ctrl.irwrite;
    assign MemWrite   = ctrl.memwrite;
    assign RegWrite   = ctrl.regwrite;
    assign ALUSrcB    = ctrl.alusrcb;
    assign ALUOp      = ctrl.aluop;
    assign PCSrc      = ctrl.pcsrc;
    assign PCEn       = ctrl.pcwrite | (ctrl.branch & zero_eff);
    assign Illegal_op = (state_eff == S_DECODE) && !is_legal;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench for multicycle_control_unit.
// Reference: per-instruction step tables; honours CTRL_BNE_EN.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode;
    logic       Zero;
    logic       IorD, ALUSrcA, RegDst, MemtoReg, IRWrite, MemWrite, RegWrite;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       PCEn, Illegal_op;

    int checks = 0;
    int errors = 0;

    localparam int C_NONE = 0, C_LS = 1, C_LW = 2, C_SW = 3;
    localparam int C_R = 4, C_BEQ = 5, C_BNE = 6, C_ADDI = 7, C_J = 8;

    int m_cls  = C_NONE;
    int m_step = 0;

    multicycle_control_unit #(.OPCODE_LENGTH(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .Opcode     (Opcode),
        .Zero       (Zero),
        .IorD       (IorD),
        .ALUSrcA    (ALUSrcA),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSrc      (PCSrc),
        .PCEn       (PCEn),
        .Illegal_op (Illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [14:0] got,
                         input logic [14:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int classify(input logic [5:0] op);
        case (op)
            6'h23, 6'h2B: return C_LS;
            6'h00: return C_R;
            6'h04: return C_BEQ;
`ifdef CTRL_BNE_EN
            6'h05: return C_BNE;
`endif
            6'h08: return C_ADDI;
            6'h02: return C_J;
            default: return C_NONE;
        endcase
    endfunction

    function automatic int steps_of(input int cls);
        case (cls)
            C_LW: return 5;
            C_SW, C_R, C_ADDI: return 4;
            default: return 3;
        endcase
    endfunction

    // Output vector: IorD ASA RegDst M2R IRW MemW RegW ASB ALUOp PCSrc PCEn Ill
    function automatic logic [14:0] model_out(input logic rst,
                                              input logic [5:0] op,
                                              input logic z);
        logic iord = 0, asa = 0, rd = 0, m2r = 0, irw = 0, mw = 0, rw = 0;
        logic [1:0] asb = 0, aop = 0, pcs = 0;
        logic pcen = 0, ill = 0;
        int st = rst ? 0 : m_step;
        if (st == 0) begin
            irw = 1; asb = 2'b01; pcen = 1;
        end else if (st == 1) begin
            asb = 2'b11; ill = (classify(op) == C_NONE);
        end else begin
            case (m_cls)
                C_LS, C_ADDI:
                    if (st == 2) begin asa = 1; asb = 2'b10; end
                    else rw = 1;
                C_LW: if (st == 3) iord = 1; else begin m2r = 1; rw = 1; end
                C_SW: begin iord = 1; mw = 1; end
                C_R:
                    if (st == 2) begin asa = 1; aop = 2'b10; end
                    else begin rd = 1; rw = 1; end
                C_BEQ, C_BNE: begin
                    asa = 1; aop = 2'b01; pcs = 2'b01;
                    pcen = (m_cls == C_BNE) ? ~z : z;
                end
                C_J: begin pcs = 2'b10; pcen = 1; end
                default: ;
            endcase
        end
        return {iord, asa, rd, m2r, irw, mw, rw, asb, aop, pcs, pcen, ill};
    endfunction

    task automatic advance(input logic rst, input logic [5:0] op);
        if (rst) begin
            m_step = 0; m_cls = C_NONE;
        end else if (m_step == 0) begin
            m_step = 1;
        end else if (m_step == 1) begin
            m_cls  = classify(op);
            m_step = (m_cls == C_NONE) ? 0 : 2;
        end else if (m_cls == C_LS) begin
            m_cls  = (op == 6'h2B) ? C_SW : C_LW;
            m_step = 3;
        end else begin
            m_step++;
            if (m_step >= steps_of(m_cls)) m_step = 0;
        end
    endtask

    task automatic cyc(input string tag, input logic rst,
                       input logic [5:0] op, input logic z);
        reset = rst; Opcode = op; Zero = z;
        #2;
        check(tag, {IorD, ALUSrcA, RegDst, MemtoReg, IRWrite, MemWrite,
                    RegWrite, ALUSrcB, ALUOp, PCSrc, PCEn, Illegal_op},
              model_out(rst, op, z));
        @(posedge clk);
        advance(rst, op);
        #1;
    endtask

    task automatic run_instr(input string tag, input logic [5:0] op,
                             input logic z, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, op, z);
    endtask

    logic [5:0] legal_ops [7];

    initial begin
        legal_ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08, 6'h02};

        cyc("reset0", 1'b1, 6'h00, 1'b0);
        cyc("reset1", 1'b1, 6'h00, 1'b0);

        run_instr("lw", 6'h23, 1'b0, 5);
        run_instr("beq_z1", 6'h04, 1'b1, 3);
        run_instr("beq_z0", 6'h04, 1'b0, 3);
        run_instr("illegal", 6'h3F, 1'b0, 3);
        run_instr("bne_z0", 6'h05, 1'b0, 3);
        run_instr("rtype", 6'h00, 1'b0, 4);
        run_instr("addi", 6'h08, 1'b0, 4);
        run_instr("jump", 6'h02, 1'b0, 3);

        run_instr("sw", 6'h2B, 1'b0, 3);
        cyc("sw_rst", 1'b1, 6'h2B, 1'b0);
        cyc("post_rst", 1'b0, 6'h2B, 1'b0);
        run_instr("after_rst", 6'h23, 1'b0, 4);

        for (int i = 0; i < 600; i++) begin
            logic       r;
            logic [5:0] op;
            r  = ($urandom_range(0, 39) == 0);
            op = ($urandom_range(0, 9) < 8) ?
                 legal_ops[$urandom_range(0, 6)] : 6'($urandom);
            cyc("random", r, op, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 The block SHALL have parameter OPCODE_LENGTH, default 6, meaning the instruction opcode width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port Opcode, input, OPCODE_LENGTH bits: instruction bits [31:26] from the instruction register.
REQ-005 The block SHALL have port Zero, input, 1 bit: ALU zero flag.
REQ-006 The block SHALL have outputs IorD, ALUSrcA, RegDst, MemtoReg, IRWrite, MemWrite and RegWrite, 1 bit each: datapath selects and enables; RegWrite drives the register file write input.
REQ-007 The block SHALL have outputs ALUSrcB, ALUOp and PCSrc, 2 bits each: operand B select, ALU operation class and next-PC select.
REQ-008 The block SHALL have output PCEn, 1 bit: program-counter load enable.
REQ-009 The block SHALL have output Illegal_op, 1 bit: one-cycle pulse on an unsupported opcode.

Function
REQ-010 The block SHALL be a Moore FSM with 4-bit state register and states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB and JUMP.
REQ-011 The block SHALL use these transitions: FETCH->DECODE; DECODE->MEMADR for 0x23 (lw) or 0x2B (sw), ->EXECUTE for 0x00 (R-type), ->BRANCH for 0x04 (beq), ->ADDIEXEC for 0x08 (addi), ->JUMP for 0x02 (j), ->FETCH for any other opcode.
REQ-012 The block SHALL continue the sequences as: MEMADR->MEMREAD (lw) or ->MEMWRITE (sw); MEMREAD->MEMWB; EXECUTE->ALUWB; ADDIEXEC->ADDIWB; and MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB and JUMP->FETCH.
REQ-013 The block SHALL decode every output from the current state only; all signals not listed for a state are 0.
REQ-014 FETCH SHALL assert IRWrite=1, ALUSrcB=01 and PCWrite.
REQ-015 DECODE SHALL assert ALUSrcB=11.
REQ-016 MEMADR and ADDIEXEC SHALL assert ALUSrcA=1 and ALUSrcB=10.
REQ-017 MEMREAD SHALL assert IorD=1; MEMWRITE SHALL assert IorD=1 and MemWrite=1.
REQ-018 MEMWB SHALL assert MemtoReg=1 and RegWrite=1; ALUWB SHALL assert RegDst=1 and RegWrite=1; ADDIWB SHALL assert RegWrite=1.
REQ-019 EXECUTE SHALL assert ALUSrcA=1 and ALUOp=10; BRANCH SHALL assert ALUSrcA=1, ALUOp=01, PCSrc=01 and Branch.
REQ-020 JUMP SHALL assert PCSrc=10 and PCWrite.
REQ-021 The block SHALL drive PCEn = PCWrite | (Branch & Zero), where PCWrite and Branch are internal.
REQ-022 Illegal_op SHALL be 1 only in the DECODE cycle whose Opcode is unsupported.
REQ-023 Instruction latency SHALL be: lw 5 cycles, sw/R-type/addi 4, beq/j 3, illegal opcode 2 (counted FETCH to return to FETCH inclusive).
REQ-024 Opcode SHALL be sampled only in DECODE and MEMADR; changes in other states SHALL have no effect.
REQ-025 An unreachable state encoding SHALL transition to FETCH on the next edge with all outputs 0.

Reset
REQ-026 With reset=1 at a rising edge, the state SHALL become FETCH, overriding any transition, including mid-instruction.
REQ-027 While in reset the outputs SHALL equal the FETCH decode; RegWrite and MemWrite SHALL be 0 in the first cycle after reset.

Configuration
REQ-028 Macro CTRL_BNE_EN SHALL, when defined, make DECODE route opcode 0x05 (bne) to the BRANCH state with an internal branch_ne flag latched.
REQ-029 With CTRL_BNE_EN defined, PCEn SHALL use ~Zero in place of Zero for bne.
REQ-030 Without CTRL_BNE_EN, 0x05 SHALL be illegal per REQ-011/REQ-022.

Structure
REQ-031 State encodings and opcode constants SHALL live in shared package mips_ctrl_pkg.
REQ-032 Output decoding SHALL be one combinational sub-module, control_output_decoder (state in, control bus out).

Verification
REQ-033 Bench: reset held 2 cycles then released -> state FETCH, IRWrite=1, PCEn=1, RegWrite=0.
REQ-034 Bench: Opcode=0x23 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1, MemtoReg=1 in cycle 5 only.
REQ-035 Bench: Opcode=0x04 with Zero=1 -> PCEn=1, PCSrc=01 in cycle 3; repeated with Zero=0 -> PCEn=0 in cycle 3.
REQ-036 Bench: Opcode=0x3F -> Illegal_op=1 in cycle 2, FETCH in cycle 3, RegWrite and MemWrite never 1.
REQ-037 Bench: reset asserted during MEMWRITE of sw (0x2B) -> FETCH next cycle, MemWrite=0.
REQ-038 Bench: Opcode=0x05 with Zero=0 -> PCEn=1 in BRANCH with CTRL_BNE_EN defined; Illegal_op=1 without it.
